// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption engine: one cipher round per clock, with round
// keys expanded on the fly. Byte 0 (first in FIPS-197 order) is the most
// significant byte of every 128-bit bus. Column c is bytes 4c..4c+3.

// Single AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the inverse for nonzero x and maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv   = gf_inv(data);
    subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// 128-bit SubBytes: sixteen parallel S-boxes.
module sub_bytes (
  input  logic [127:0] data,
  output logic [127:0] subst
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (data[8*g +: 8]),
      .subst (subst[8*g +: 8])
    );
  end

endmodule

// Control FSM, datapath and on-the-fly key schedule.
module aes128_enc_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   round_cnt;

  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] next_key;
  logic [127:0] round_out;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  key_temp;
  logic [31:0]  nk0, nk1, nk2, nk3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  sub_bytes u_sub_bytes (
    .data  (state_reg),
    .subst (sb_out)
  );

  // RotWord of the last key word feeds the dedicated SubWord S-boxes.
  assign rot_word = {key_reg[23:0], key_reg[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .data  (rot_word[8*g +: 8]),
      .subst (sub_word[8*g +: 8])
    );
  end

  // Next round key and the result of the current round; round 10 skips MixColumns.
  always_comb begin
    key_temp  = sub_word ^ {rcon(round_cnt), 24'h000000};
    nk0       = key_reg[127:96] ^ key_temp;
    nk1       = key_reg[95:64] ^ nk0;
    nk2       = key_reg[63:32] ^ nk1;
    nk3       = key_reg[31:0] ^ nk2;
    next_key  = {nk0, nk1, nk2, nk3};
    sr_out    = shift_rows(sb_out);
    mc_out    = mix_columns(sr_out);
    round_out = (round_cnt == 4'd10) ? (sr_out ^ next_key) : (mc_out ^ next_key);
  end

  // Sequencer with registered handshake outputs; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      round_cnt  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          ciphertext <= '0;
          if (in_valid && in_ready) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            round_cnt <= 4'd1;
            fsm       <= ROUND;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          key_reg   <= next_key;
          if (round_cnt == 4'd10) begin
            fsm        <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            ciphertext <= round_out;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm        <= IDLE;
            out_valid  <= 1'b0;
            ciphertext <= '0;
            in_ready   <= 1'b1;
            round_cnt  <= '0;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes128_enc_ctrl.md
AES128_ENC_CTRL -- requirements
Module: aes128_enc_ctrl

Interface
REQ-001 Parameters: none; the block SHALL be fixed to AES-128 encryption (10 rounds).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  block can accept a new plaintext/key.
REQ-006 plaintext  input  128  [0:127]; byte k occupies bits 8k..8k+7, and byte 0 is first in FIPS-197 order.
REQ-007 key  input  128  [0:127] cipher key, same byte order.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ciphertext  output  128  [0:127] result, same byte order.
REQ-011 busy  output  1  high in ROUND state.

Function
REQ-012 The block SHALL sequence one iterative AES-128 round per clock, using one instance of the existing 128-bit combinational sub_bytes module for the state SubBytes step.
REQ-013 The block SHALL implement ShiftRows, MixColumns and AddRoundKey internally, column-major (column c = bytes 4c..4c+3).
REQ-014 The block SHALL expand round keys on the fly, one per round, with a dedicated 32-bit SubWord S-box, RotWord and Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-015 FSM states SHALL be IDLE, ROUND and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, state_reg <= plaintext^key, key_reg <= key, round counter <= 1, next state ROUND.
REQ-017 ROUND (counter 1..9): state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next round key; key_reg <= next round key; counter +1.
REQ-018 ROUND, counter=10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ round key 10 (no MixColumns); next state DONE.
REQ-019 DONE: out_valid=1 and ciphertext=state_reg; on out_ready, next state IDLE.
REQ-020 Latency: if the accept handshake occurs in cycle T, out_valid SHALL first be high in cycle T+11.
REQ-021 The round counter SHALL be 4 bits; values 0 and 11..15 SHALL never occur outside IDLE.
REQ-022 in_ready SHALL be 0 in ROUND and DONE; in_valid in those states SHALL be ignored with no state change.
REQ-023 Minimum spacing between accepts SHALL be 12 cycles (accept, 10 rounds, 1 DONE cycle with out_ready=1).
REQ-024 ciphertext and out_valid SHALL stay stable while out_valid=1 and out_ready=0 (backpressure of any length).
REQ-025 plaintext and key SHALL be sampled only in the accept cycle; later changes SHALL NOT affect the result.
REQ-026 ciphertext SHALL read 0 whenever out_valid=0.
REQ-027 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-028 On rst_n=0, at any time including mid-ROUND or in DONE, the block SHALL immediately force the FSM to IDLE and clear state_reg, key_reg and the counter to 0.
REQ-029 During reset: in_ready=0, out_valid=0, busy=0, ciphertext=0.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-031 An operation interrupted by reset SHALL produce no out_valid pulse.

Verification
REQ-032 FIPS-197 App. B test: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> ciphertext=3925841d02dc09fbdc118597196a0b32, with out_valid at T+11.
REQ-033 FIPS-197 App. C.1 test: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Backpressure test: hold out_ready=0 for 20 cycles after out_valid, then pulse it for 1 cycle.
  - Required: ciphertext is constant throughout.
  - Required: in_ready=0 until the pulse, then 1 in the next cycle.
REQ-035 Busy-input test: change plaintext/key and hold in_valid=1 during ROUND.
  - Required: the first result is unchanged.
  - Required: the second vector is accepted only after returning to IDLE, and 2 back-to-back vectors complete 12 cycles apart.
REQ-036 Reset-mid-round test: assert rst_n=0 at round 5.
  - Required: outputs are 0 asynchronously.
  - Required: no out_valid occurs.
  - Required: a subsequent App. B vector yields the correct ciphertext.
